// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: sizes, the FSM
// state type and the rotating-priority pick helper.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // First set bit of mask, searching ptr, ptr+1, ... and wrapping 3 -> 0.
  // Returns ptr when the mask is empty; callers only use it on a non-zero mask.
  function automatic logic [SEL_W-1:0] pick(input logic [NUM_REQ-1:0] mask,
                                            input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] res;
    logic             found;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Binary index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    return NUM_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/mux64_4_1.sv
// 4:1 multiplexer for 64-bit payloads.
module mux64_4_1
  import arb_pkg::*;
(
  input  logic [63:0]      in [NUM_REQ-1:0],
  input  logic [SEL_W-1:0] sel,
  output logic [63:0]      out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_arbiter64_4.sv
// Round-robin arbiter sharing one 64-bit valid/ready port among four
// requesters. The grant is held until accepted; a watchdog drops a grant
// that stays unaccepted for TIMEOUT cycles (0 disables the watchdog).
module rr_arbiter64_4
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [63:0]        data_in [NUM_REQ-1:0],
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic               out_valid,
  output logic [SEL_W-1:0]   out_sel,
  output logic [63:0]        out_data,
  output logic               timeout_err
);

  // A disabled watchdog would give a zero-width counter; keep one bit instead.
  localparam int  WCNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit  WDOG_EN = (TIMEOUT > 0);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   ptr_q,   ptr_d;
  logic [WCNT_W-1:0]  wcnt_q,  wcnt_d;
  logic               terr_q,  terr_d;
  logic [NUM_REQ-1:0] others;

  // Requesters other than the current owner, eligible for a back-to-back regrant.
  assign others = req & ~gnt_q;

  // Next-state logic: grant in IDLE; accept / abort / timeout / wait in BUSY.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    terr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          sel_d   = pick(req, ptr_q);
          gnt_d   = onehot(sel_d);
          state_d = BUSY;
          wcnt_d  = '0;
        end
      end
      BUSY: begin
        if (out_ready) begin
          // Accept wins over abort and timeout; the pointer moves past the owner.
          ptr_d = sel_q + 1'b1;
          if (others != '0) begin
            sel_d  = pick(others, ptr_d);
            gnt_d  = onehot(sel_d);
            wcnt_d = '0;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (!req[sel_q]) begin
          // Owner withdrew before acceptance: drop silently.
          gnt_d   = '0;
          ptr_d   = sel_q + 1'b1;
          state_d = IDLE;
        end else if (WDOG_EN && (wcnt_q == WCNT_LAST)) begin
          gnt_d   = '0;
          ptr_d   = sel_q + 1'b1;
          state_d = IDLE;
          terr_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      terr_q  <= terr_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = gnt_q & {NUM_REQ{out_ready}};
  assign out_valid   = (state_q == BUSY);
  assign out_sel     = sel_q;
  assign timeout_err = terr_q;

  mux64_4_1 u_mux (
    .in  (data_in),
    .sel (sel_q),
    .out (out_data)
  );

endmodule

// File: tb/tb_rr_arbiter64_4.sv
// Self-checking bench for rr_arbiter64_4 (TIMEOUT = 4): directed vector
// table, hand-written reset sequences, and randomized traffic against a
// behavioural model.
module tb_rr_arbiter64_4;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] data_in [3:0];
  logic        out_ready;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        out_valid;
  logic [1:0]  out_sel;
  logic [63:0] out_data;
  logic        timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  rr_arbiter64_4 #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .data_in     (data_in),
    .out_ready   (out_ready),
    .gnt         (gnt),
    .ack         (ack),
    .out_valid   (out_valid),
    .out_sel     (out_sel),
    .out_data    (out_data),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Directed vectors: inputs applied for one cycle, outputs expected in that cycle.
  typedef struct packed {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       terr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic y, input logic [3:0] g,
                     input logic [3:0] a, input logic [1:0] s, input logic t);
    vec_t v;
    v.req = r; v.rdy = y; v.gnt = g; v.ack = a; v.sel = s; v.terr = t;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural model: owner index (-1 when none), priority pointer,
  // cycles the current grant has waited, last selected index, error pulse.
  int m_owner, m_ptr, m_wait, m_sel;
  bit m_terr;

  function automatic int first_from(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic y);
    int o;
    logic [3:0] rest;
    o = m_owner;
    m_terr = 1'b0;
    if (o < 0) begin
      if (r != 0) begin
        m_owner = first_from(r, m_ptr);
        m_sel = m_owner; m_wait = 0;
      end
    end else if (y) begin
      m_ptr = (o + 1) % 4;
      rest = r;
      rest[o] = 1'b0;
      if (rest != 0) begin
        m_owner = first_from(rest, m_ptr);
        m_sel = m_owner; m_wait = 0;
      end else m_owner = -1;
    end else if (!r[o]) begin
      m_ptr = (o + 1) % 4; m_owner = -1;
    end else if (m_wait + 1 == TO) begin
      m_ptr = (o + 1) % 4; m_owner = -1; m_terr = 1'b1;
    end else m_wait++;
  endtask

  initial begin
    logic [3:0] exp_g;
    int rdy_pct;
    reset = 1'b1; req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) data_in[i] = 64'hDEAD_BEEF_0000_0000 + 64'(i);

    // Reset held with all requests up: everything quiet.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_ack", 64'(ack), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_terr", 64'(timeout_err), 64'h0);
    check("rst_sel", 64'(out_sel), 64'h0);
    check("rst_data", out_data, 64'hDEAD_BEEF_0000_0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_first_gnt", 64'(gnt), 64'h1);

    // Directed table starting from a fresh reset (ptr = 0).
    add(4'b0000,0,4'b0000,4'b0000,0,0);
    add(4'b1111,1,4'b0000,4'b0000,0,0);
    add(4'b1111,1,4'b0001,4'b0001,0,0);  // fairness rotation
    add(4'b1111,1,4'b0010,4'b0010,1,0);
    add(4'b1111,1,4'b0100,4'b0100,2,0);
    add(4'b1111,1,4'b1000,4'b1000,3,0);
    add(4'b0001,1,4'b0001,4'b0001,0,0);
    add(4'b0100,1,4'b0000,4'b0000,0,0);  // single request
    add(4'b0100,1,4'b0100,4'b0100,2,0);
    add(4'b0000,1,4'b0000,4'b0000,2,0);
    add(4'b0110,0,4'b0000,4'b0000,2,0);  // abort
    add(4'b0110,0,4'b0010,4'b0000,1,0);
    add(4'b0100,0,4'b0010,4'b0000,1,0);
    add(4'b0100,0,4'b0000,4'b0000,1,0);
    add(4'b0100,1,4'b0100,4'b0100,2,0);
    add(4'b0000,0,4'b0000,4'b0000,2,0);
    add(4'b0011,0,4'b0000,4'b0000,2,0);  // watchdog
    for (int i = 0; i < 4; i++) add(4'b0011,0,4'b0001,4'b0000,0,0);
    add(4'b0011,0,4'b0000,4'b0000,0,1);
    add(4'b0011,0,4'b0010,4'b0000,1,0);
    add(4'b0011,1,4'b0010,4'b0010,1,0);  // back-to-back regrant wraps to 0
    add(4'b0001,1,4'b0001,4'b0001,0,0);
    add(4'b1000,0,4'b0000,4'b0000,0,0);  // accept while req falls
    add(4'b1000,0,4'b1000,4'b0000,3,0);
    add(4'b0000,1,4'b1000,4'b1000,3,0);
    add(4'b0000,0,4'b0000,4'b0000,3,0);
    add(4'b0100,0,4'b0000,4'b0000,3,0);  // accept beats timeout
    for (int i = 0; i < 3; i++) add(4'b0100,0,4'b0100,4'b0000,2,0);
    add(4'b0100,1,4'b0100,4'b0100,2,0);
    add(4'b0000,0,4'b0000,4'b0000,2,0);

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      req = tbl[i].req; out_ready = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
      check($sformatf("vec%0d_ack", i), 64'(ack), 64'(tbl[i].ack));
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(|tbl[i].gnt));
      check($sformatf("vec%0d_sel", i), 64'(out_sel), 64'(tbl[i].sel));
      check($sformatf("vec%0d_data", i), out_data, data_in[tbl[i].sel]);
      check($sformatf("vec%0d_terr", i), 64'(timeout_err), 64'(tbl[i].terr));
    end

    // Asynchronous reset in the middle of a grant to requester 3.
    do_reset();
    @(negedge clk);
    req = 4'b1000; out_ready = 1'b0;
    @(negedge clk); #1;
    check("areset_pre_gnt", 64'(gnt), 64'h8);
    #2;
    out_ready = 1'b1; reset = 1'b1;
    #1;
    check("areset_gnt", 64'(gnt), 64'h0);
    check("areset_valid", 64'(out_valid), 64'h0);
    check("areset_ack", 64'(ack), 64'h0);
    @(negedge clk);
    reset = 1'b0; req = 4'b1111; out_ready = 1'b0;
    @(posedge clk); #1;
    check("areset_ptr0_gnt", 64'(gnt), 64'h1);

    // Randomized traffic against the behavioural model.
    do_reset();
    m_owner = -1; m_ptr = 0; m_wait = 0; m_sel = 0; m_terr = 1'b0;
    rdy_pct = 75;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 100 == 0) rdy_pct = ((c / 100) % 3 == 0) ? 10 : 75;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) req[i] = ($urandom_range(0, 15) != 0);
        else        req[i] = ($urandom_range(0, 2) == 0);
        data_in[i] = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      exp_g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      check($sformatf("rnd%0d_gnt", c), 64'(gnt), 64'(exp_g));
      check($sformatf("rnd%0d_ack", c), 64'(ack), 64'(out_ready ? exp_g : 4'b0000));
      check($sformatf("rnd%0d_valid", c), 64'(out_valid), 64'(m_owner >= 0));
      check($sformatf("rnd%0d_sel", c), 64'(out_sel), 64'(m_sel));
      check($sformatf("rnd%0d_data", c), out_data, data_in[m_sel]);
      check($sformatf("rnd%0d_terr", c), 64'(timeout_err), 64'(m_terr));
      @(posedge clk);
      model_step(req, out_ready);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
